// File: rtl/trig_pkg.sv
// Shared types and sizes for the trigger-rate histogrammer.
// Channel count and widths match the serial processor's histos[8].
package trig_pkg;

  localparam int NCH   = 8;
  localparam int CNT_W = 32;
  localparam int DT_W  = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic {
    IDLE,
    DEAD
  } ch_state_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/hist_channel.sv
// One trigger line: 2-flop synchroniser, rising-edge detect,
// dead-time FSM and saturating event counter.
module hist_channel
  import trig_pkg::*;
#(
  parameter int CW = CNT_W,
  parameter int DW = DT_W
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          trig_in,
  input  logic [DW-1:0] deadticks,
  input  logic          clr,
  input  logic          count_en,
  output logic [CW-1:0] count,
  output logic          dead_busy,
  output logic          sat_flag
);

  localparam logic [CW-1:0] MAX = CNT_MAX[CW-1:0];

  logic          s1_q, s2_q, s3_q;
  logic          edge_det;
  ch_state_t     state_q, state_d;
  logic [DW-1:0] dtc_q, dtc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sat_q, sat_d;

  assign edge_det = s2_q & ~s3_q;

  always_comb begin
    state_d = state_q;
    dtc_d   = dtc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    // a clear always beats a same-cycle event
    if (clr) begin
      state_d = IDLE;
      dtc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (edge_det && count_en) begin
            if (cnt_q == MAX) sat_d = 1'b1;
            else              cnt_d = cnt_q + CW'(1);
            if (deadticks != '0) begin
              state_d = DEAD;
              dtc_d   = deadticks;
            end
          end
        end
        DEAD: begin
          dtc_d = dtc_q - DW'(1);
          if (dtc_q == DW'(1)) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      state_q <= IDLE;
      dtc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      s1_q    <= trig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      state_q <= state_d;
      dtc_q   <= dtc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign count     = cnt_q;
  assign dead_busy = (state_q == DEAD);
  assign sat_flag  = sat_q;

endmodule

// File: rtl/trigger_rate_histogrammer.sv
// Per-channel trigger-rate histograms for the serial processor.
// Holds only the resethist edge detector and the channel array.
module trigger_rate_histogrammer #(
  parameter int NCH   = trig_pkg::NCH,
  parameter int CNT_W = trig_pkg::CNT_W,
  parameter int DT_W  = trig_pkg::DT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   trig_in,
  input  logic [DT_W-1:0]  deadticks,
  input  logic             resethist,
  input  logic             count_en,
  output logic [CNT_W-1:0] histos [NCH],
  output logic [NCH-1:0]   dead_busy,
  output logic [NCH-1:0]   sat_flag
);

  logic rh_q, rh_d;
  logic clr;

  always_comb rh_d = resethist;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rh_q <= 1'b0;
    else       rh_q <= rh_d;
  end

  // a held-high resethist clears only once
  assign clr = resethist & ~rh_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    hist_channel #(
      .CW(CNT_W),
      .DW(DT_W)
    ) u_ch (
      .clk      (clk),
      .rstn     (rstn),
      .trig_in  (trig_in[g]),
      .deadticks(deadticks),
      .clr      (clr),
      .count_en (count_en),
      .count    (histos[g]),
      .dead_busy(dead_busy[g]),
      .sat_flag (sat_flag[g])
    );
  end

endmodule

// File: tb/tb_trigger_rate_histogrammer.sv
// Bench for trigger_rate_histogrammer: directed scenarios then random
// traffic, all checked against an event-time reference model.
module tb_trigger_rate_histogrammer;

  localparam int NCH = 8;
  localparam int SW  = 3;
  localparam longint unsigned MAXB = 64'hFFFF_FFFF;
  localparam longint unsigned MAXS = 7;

  logic           clk = 1'b0;
  logic           rstn;
  logic [NCH-1:0] trig_in;
  logic [7:0]     deadticks;
  logic           resethist;
  logic           count_en;
  logic [31:0]    histos   [NCH];
  logic [SW-1:0]  histos_s [NCH];
  logic [NCH-1:0] dead_busy, sat_flag;
  logic [NCH-1:0] dead_busy_s, sat_flag_s;

  trigger_rate_histogrammer dut (
    .clk(clk), .rstn(rstn), .trig_in(trig_in),
    .deadticks(deadticks), .resethist(resethist),
    .count_en(count_en), .histos(histos),
    .dead_busy(dead_busy), .sat_flag(sat_flag)
  );

  trigger_rate_histogrammer #(.CNT_W(SW)) dut_s (
    .clk(clk), .rstn(rstn), .trig_in(trig_in),
    .deadticks(deadticks), .resethist(resethist),
    .count_en(count_en), .histos(histos_s),
    .dead_busy(dead_busy_s), .sat_flag(sat_flag_s)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: counts, sticky flags, earliest countable edge
  longint unsigned m_cnt   [NCH];
  longint unsigned m_cnt_s [NCH];
  longint          m_ready [NCH];
  logic [NCH-1:0]  m_sat, m_sat_s, m_busy;
  logic [NCH-1:0]  w0, w1, w2, w3;
  logic            m_rh;
  longint          n_edge = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c]   = 0;
      m_cnt_s[c] = 0;
      m_ready[c] = 0;
    end
    m_sat = '0; m_sat_s = '0; m_busy = '0;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    m_rh = 1'b0;
  endfunction

  function automatic void model_step();
    logic clr;
    if (!rstn) begin
      model_reset();
      return;
    end
    w3 = w2; w2 = w1; w1 = w0; w0 = trig_in;
    clr  = resethist & ~m_rh;
    m_rh = resethist;
    for (int c = 0; c < NCH; c++) begin
      if (clr) begin
        m_cnt[c] = 0; m_cnt_s[c] = 0;
        m_sat[c] = 1'b0; m_sat_s[c] = 1'b0;
        m_ready[c] = 0;
      end else if (w2[c] && !w3[c] && count_en
                   && n_edge >= m_ready[c]) begin
        if (m_cnt[c] == MAXB) m_sat[c] = 1'b1;
        else                  m_cnt[c]++;
        if (m_cnt_s[c] == MAXS) m_sat_s[c] = 1'b1;
        else                    m_cnt_s[c]++;
        if (deadticks != 0)
          m_ready[c] = n_edge + longint'(deadticks) + 1;
      end
      m_busy[c] = (n_edge < m_ready[c] - 1);
    end
    n_edge++;
  endfunction

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("histos[%0d]", c), 64'(histos[c]), m_cnt[c]);
      chk($sformatf("histos_s[%0d]", c), 64'(histos_s[c]), m_cnt_s[c]);
    end
    chk("dead_busy", 64'(dead_busy), 64'(m_busy));
    chk("dead_busy_s", 64'(dead_busy_s), 64'(m_busy));
    chk("sat_flag", 64'(sat_flag), 64'(m_sat));
    chk("sat_flag_s", 64'(sat_flag_s), 64'(m_sat_s));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(int k);
    repeat (k) cycle();
  endtask

  task automatic pulses(logic [NCH-1:0] mask, int num, int hi, int lo);
    repeat (num) begin
      trig_in = trig_in | mask;
      run(hi);
      trig_in = trig_in & ~mask;
      run(lo);
    end
  endtask

  task automatic async_reset();
    #2 rstn = 1'b0;
    model_reset();
    #1 check_all();
    cycle();
    rstn = 1'b1;
  endtask

  longint unsigned snap [NCH];

  initial begin
    rstn = 1'b0; trig_in = '0; deadticks = '0;
    resethist = 1'b0; count_en = 1'b1;
    model_reset();
    run(3);
    rstn = 1'b1;
    run(3);

    // latency: count visible after the third edge
    trig_in[0] = 1'b1;
    cycle(); cycle();
    chk("lat_edge2", 64'(histos[0]), 0);
    cycle();
    chk("lat_edge3", 64'(histos[0]), 1);
    run(2);
    trig_in[0] = 1'b0;
    run(5);

    // dead-time window on ch2
    deadticks = 8'd10;
    for (int c = 0; c < 17; c++) begin
      trig_in[2] = (c < 2) || (c >= 6 && c < 8) || (c >= 11 && c < 15);
      cycle();
    end
    trig_in[2] = 1'b0;
    run(15);
    chk("dw_h2", 64'(histos[2]), 2);

    // clear: bring ch5 to 42, then clear with a colliding event
    deadticks = 8'd0;
    pulses(8'h20, 42, 1, 1);
    run(4);
    chk("h5_42", 64'(histos[5]), 42);
    deadticks = 8'd5;
    trig_in[5] = 1'b1;
    cycle(); cycle();
    resethist = 1'b1;
    cycle();
    chk("clr_h5", 64'(histos[5]), 0);
    chk("clr_nodead", 64'(dead_busy[5]), 0);
    trig_in[5] = 1'b0;
    run(3);
    pulses(8'h20, 1, 2, 10);
    chk("held_h5_1", 64'(histos[5]), 1);
    pulses(8'h20, 1, 2, 10);
    chk("held_h5_2", 64'(histos[5]), 2);
    resethist = 1'b0;
    run(2);

    // saturation on the narrow instance, ch7
    deadticks = 8'd0;
    pulses(8'h80, 10, 1, 1);
    run(4);
    chk("sat_h7", 64'(histos_s[7]), MAXS);
    chk("sat_f7", 64'(sat_flag_s[7]), 1);
    resethist = 1'b1;
    cycle();
    chk("sat_clr_h7", 64'(histos_s[7]), 0);
    chk("sat_clr_f7", 64'(sat_flag_s[7]), 0);
    resethist = 1'b0;
    run(2);

    // gating, then all channels at once
    count_en = 1'b0;
    for (int c = 0; c < NCH; c++) snap[c] = m_cnt[c];
    pulses('1, 1, 2, 5);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("gate_h%0d", c), 64'(histos[c]), snap[c]);
    count_en = 1'b1;
    pulses('1, 1, 2, 5);
    for (int c = 0; c < NCH; c++)
      chk($sformatf("par_h%0d", c), 64'(histos[c]), snap[c] + 1);

    // async reset with ch3 at 17
    resethist = 1'b1;
    cycle();
    resethist = 1'b0;
    pulses(8'h08, 17, 1, 1);
    run(4);
    chk("h3_17", 64'(histos[3]), 17);
    #2 rstn = 1'b0;
    model_reset();
    #1;
    chk("rst_h3", 64'(histos[3]), 0);
    chk("rst_busy", 64'(dead_busy), 0);
    chk("rst_sat", 64'(sat_flag), 0);
    cycle();
    rstn = 1'b1;
    run(2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) trig_in[c] = ~trig_in[c];
      if ($urandom_range(0, 60) == 0)
        deadticks = ($urandom_range(0, 2) == 0) ? 8'd0
                                                : 8'($urandom_range(1, 6));
      count_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) resethist = ~resethist;
      if ($urandom_range(0, 799) == 0) async_reset();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
